// File: rtl/kalman_pkg.sv
// Shared types and helpers for the N-channel scalar Kalman tracker.
package kalman_pkg;

   // Sequencing states of the time-shared update lane.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      OUT  = 2'd2
   } state_t;

   // Default number of fractional bits in the gain word.
   localparam int K_FRAC_DEFAULT = 10;

   // Working width of the saturation helper; callers sign-extend into it.
   localparam int SAT_W = 128;

   // Clamp a signed value to the two's-complement range of 'width' bits.
   function automatic logic signed [SAT_W-1:0] saturate(
      input logic signed [SAT_W-1:0] val,
      input int unsigned             width
   );
      logic signed [SAT_W-1:0] one_v;
      logic signed [SAT_W-1:0] max_v;
      logic signed [SAT_W-1:0] min_v;
      logic signed [SAT_W-1:0] res_v;
      one_v = {{(SAT_W-1){1'b0}}, 1'b1};
      max_v = (one_v <<< (width - 32'd1)) - one_v;
      min_v = ~max_v;
      if (val > max_v) begin
         res_v = max_v;
      end else if (val < min_v) begin
         res_v = min_v;
      end else begin
         res_v = val;
      end
      return res_v;
   endfunction

endpackage

// File: rtl/kalman_update_lane.sv
// Combinational single-channel update: innovation, gate, gain multiply,
// floor shift and saturating accumulate.
module kalman_update_lane
   import kalman_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int K_WIDTH    = 16,
   parameter int K_FRAC     = K_FRAC_DEFAULT
) (
   input  logic                  init_done,
   input  logic [DATA_WIDTH-1:0] x_cur,
   input  logic [DATA_WIDTH-1:0] z,
   input  logic [K_WIDTH-1:0]    k_gain,
   input  logic [DATA_WIDTH-1:0] gate_thresh,
   output logic [DATA_WIDTH-1:0] x_next,
   output logic                  rejected
);

   localparam int PROD_W = DATA_WIDTH + K_WIDTH + 2;
   localparam int SUM_W  = PROD_W + 1;

   logic signed [DATA_WIDTH:0]   innov_s;
   logic        [DATA_WIDTH:0]   abs_innov_s;
   logic signed [PROD_W-1:0]     prod_s;
   logic signed [PROD_W-1:0]     delta_s;
   logic signed [SUM_W-1:0]      sum_s;
   logic signed [SAT_W-1:0]      sat_in_s;
   logic                         gate_hit_s;

   // Datapath for one channel; innovation is one bit wider so it never wraps.
   always_comb begin
      innov_s     = {z[DATA_WIDTH-1], z} - {x_cur[DATA_WIDTH-1], x_cur};
      abs_innov_s = innov_s[DATA_WIDTH] ? (-innov_s) : innov_s;
      gate_hit_s  = (gate_thresh != {DATA_WIDTH{1'b0}}) &&
                    (abs_innov_s > {1'b0, gate_thresh});
      prod_s      = innov_s * $signed({1'b0, k_gain});
      delta_s     = prod_s >>> K_FRAC;
      sum_s       = {delta_s[PROD_W-1], delta_s} +
                    {{(SUM_W-DATA_WIDTH){x_cur[DATA_WIDTH-1]}}, x_cur};
      sat_in_s    = {{(SAT_W-SUM_W){sum_s[SUM_W-1]}}, sum_s};
      if (!init_done) begin
         x_next   = z;
         rejected = 1'b0;
      end else if (gate_hit_s) begin
         x_next   = x_cur;
         rejected = 1'b1;
      end else begin
         x_next   = DATA_WIDTH'(saturate(sat_in_s, DATA_WIDTH));
         rejected = 1'b0;
      end
   end

endmodule

// File: rtl/kalman_track_nd.sv
// N-channel fixed-point scalar Kalman tracker with one time-shared update lane,
// first-sample initialisation, innovation gating and output saturation.
module kalman_track_nd
   import kalman_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int N_CH       = 3,
   parameter int K_WIDTH    = 16,
   parameter int K_FRAC     = K_FRAC_DEFAULT
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clear,
   input  logic [K_WIDTH-1:0]         k_gain,
   input  logic [DATA_WIDTH-1:0]      gate_thresh,
   input  logic                       z_valid,
   output logic                       z_ready,
   input  logic [N_CH*DATA_WIDTH-1:0] z_in,
   output logic                       x_valid,
   input  logic                       x_ready,
   output logic [N_CH*DATA_WIDTH-1:0] x_out,
   output logic [N_CH-1:0]            x_rejected,
   output logic                       initialized
);

   localparam int                CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam logic [CH_W-1:0]   CH_LAST = CH_W'(N_CH - 1);

   state_t                     state_r;
   logic [CH_W-1:0]            ch_r;
   logic [N_CH*DATA_WIDTH-1:0] z_cap_r;
   logic [K_WIDTH-1:0]         k_cap_r;
   logic [DATA_WIDTH-1:0]      thr_cap_r;
   logic [N_CH*DATA_WIDTH-1:0] x_est_r;
   logic [N_CH-1:0]            rej_r;

   int                         ch_idx_s;
   logic [DATA_WIDTH-1:0]      lane_x_cur_s;
   logic [DATA_WIDTH-1:0]      lane_z_s;
   logic [DATA_WIDTH-1:0]      lane_x_s;
   logic                       lane_rej_s;
   logic [N_CH*DATA_WIDTH-1:0] x_est_next_s;
   logic [N_CH-1:0]            rej_next_s;

   // Select the active channel for the lane and merge its result back.
   always_comb begin
      ch_idx_s     = int'(ch_r);
      lane_x_cur_s = x_est_r[ch_idx_s*DATA_WIDTH +: DATA_WIDTH];
      lane_z_s     = z_cap_r[ch_idx_s*DATA_WIDTH +: DATA_WIDTH];
      x_est_next_s = x_est_r;
      x_est_next_s[ch_idx_s*DATA_WIDTH +: DATA_WIDTH] = lane_x_s;
      rej_next_s   = rej_r;
      rej_next_s[ch_idx_s] = lane_rej_s;
   end

   kalman_update_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .K_WIDTH    (K_WIDTH),
      .K_FRAC     (K_FRAC)
   ) u_lane (
      .init_done   (initialized),
      .x_cur       (lane_x_cur_s),
      .z           (lane_z_s),
      .k_gain      (k_cap_r),
      .gate_thresh (thr_cap_r),
      .x_next      (lane_x_s),
      .rejected    (lane_rej_s)
   );

   // Control FSM, capture registers, estimate file and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         ch_r        <= {CH_W{1'b0}};
         z_cap_r     <= {(N_CH*DATA_WIDTH){1'b0}};
         k_cap_r     <= {K_WIDTH{1'b0}};
         thr_cap_r   <= {DATA_WIDTH{1'b0}};
         x_est_r     <= {(N_CH*DATA_WIDTH){1'b0}};
         rej_r       <= {N_CH{1'b0}};
         initialized <= 1'b0;
         x_valid     <= 1'b0;
         x_out       <= {(N_CH*DATA_WIDTH){1'b0}};
         x_rejected  <= {N_CH{1'b0}};
         z_ready     <= 1'b0;
      end else if (clear) begin
         // Drop estimates; the stale x_out stays visible but is not valid.
         state_r     <= IDLE;
         ch_r        <= {CH_W{1'b0}};
         initialized <= 1'b0;
         x_valid     <= 1'b0;
         z_ready     <= 1'b1;
      end else begin
         case (state_r)
            IDLE: begin
               if (z_valid && z_ready) begin
                  z_cap_r   <= z_in;
                  k_cap_r   <= k_gain;
                  thr_cap_r <= gate_thresh;
                  ch_r      <= {CH_W{1'b0}};
                  state_r   <= CALC;
                  z_ready   <= 1'b0;
               end else begin
                  z_ready   <= 1'b1;
               end
            end
            CALC: begin
               x_est_r <= x_est_next_s;
               rej_r   <= rej_next_s;
               if (ch_r == CH_LAST) begin
                  state_r     <= OUT;
                  x_valid     <= 1'b1;
                  x_out       <= x_est_next_s;
                  x_rejected  <= rej_next_s;
                  initialized <= 1'b1;
               end else begin
                  ch_r <= ch_r + CH_W'(1);
               end
            end
            OUT: begin
               if (x_ready) begin
                  state_r <= IDLE;
                  x_valid <= 1'b0;
                  z_ready <= 1'b1;
               end else begin
                  state_r <= OUT;
               end
            end
            default: begin
               state_r <= IDLE;
               x_valid <= 1'b0;
               z_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule
